// File: rtl/ft_freeze_ctrl.sv
// -----------------------------------------------------------------------------
// ft_freeze_ctrl
//
// Emulates a slower memory by freezing the CPU clock after a data-bus
// transaction completes faster than the configured target latency. The block
// measures the actual latency of each read/write (start cycle counts as 1).
// If the ack arrives before the target, it holds freeze high for the
// remaining (target - actual) cycles. It also keeps saturating statistics
// counters.
//
// Ports
//   clock       in   module clock, rising edge
//   reset       in   synchronous, active-high reset
//   enable      in   freeze emulation enable
//   clr         in   synchronous clear of all statistics counters
//   ibus_stall  in   instruction-bus stall flag
//   dbus_read   in   data-bus read flag (wins over write when both high)
//   dbus_write  in   data-bus write flag
//   dbus_stall  in   data-bus stall flag
//   dbus_ack    in   raw data-bus ack
//   freeze      out  registered CPU clock-freeze request
//   busy        out  high whenever the controller is not idle
//   rd_cnt      out  accepted read starts
//   wr_cnt      out  accepted write starts
//   istall_cnt  out  cycles with ibus_stall high
//   dstall_cnt  out  cycles with dbus_stall high
//   freeze_cnt  out  cycles with freeze high
// -----------------------------------------------------------------------------
module ft_freeze_ctrl #(
    parameter int READ_LAT  = 20,
    parameter int WRITE_LAT = 12,
    parameter int LAT_W     = 8,
    parameter int CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr,
    input  logic             ibus_stall,
    input  logic             dbus_read,
    input  logic             dbus_write,
    input  logic             dbus_stall,
    input  logic             dbus_ack,
    output logic             freeze,
    output logic             busy,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_FREEZE = 2'd2
    } state_t;

    localparam logic [LAT_W-1:0] RD_TGT  = LAT_W'(READ_LAT);
    localparam logic [LAT_W-1:0] WR_TGT  = LAT_W'(WRITE_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [LAT_W-1:0] lat_sat_inc(input logic [LAT_W-1:0] v);
        return (v == LAT_MAX) ? v : v + LAT_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v,
                                                     input logic             inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_ONE : v;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic             r_type;          // 1 = read, 0 = write
    logic             w_next_type;
    logic [LAT_W-1:0] r_elapsed;
    logic [LAT_W-1:0] w_next_elapsed;
    logic [LAT_W-1:0] r_remain;
    logic [LAT_W-1:0] w_next_remain;
    logic             r_freeze;
    logic             w_start;
    logic [LAT_W-1:0] w_start_tgt;
    logic [LAT_W-1:0] w_cur_tgt;
    logic [LAT_W-1:0] w_actual;

    // -------------------------------------------------------------------------
    // State and transaction registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_type    <= 1'b0;
            r_elapsed <= '0;
            r_remain  <= '0;
            r_freeze  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_type    <= w_next_type;
            r_elapsed <= w_next_elapsed;
            r_remain  <= w_next_remain;
            // freeze is high for every cycle spent in FREEZE, registered so
            // no input reaches the output combinationally.
            r_freeze  <= (w_next_state == S_FREEZE);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_next_type    = r_type;
        w_next_elapsed = r_elapsed;
        w_next_remain  = r_remain;
        w_start        = 1'b0;
        w_start_tgt    = dbus_read ? RD_TGT : WR_TGT;
        w_cur_tgt      = r_type ? RD_TGT : WR_TGT;
        // Latency if the ack arrives this cycle (the start cycle was cycle 1).
        w_actual       = lat_sat_inc(r_elapsed);

        case (r_state)
            S_IDLE: begin
                if (enable && (dbus_read || dbus_write)) begin
                    w_start     = 1'b1;
                    w_next_type = dbus_read;
                    if (dbus_ack) begin
                        // Single-cycle transaction: actual latency is 1.
                        if (w_start_tgt > LAT_ONE) begin
                            w_next_state  = S_FREEZE;
                            w_next_remain = w_start_tgt - LAT_ONE;
                        end
                    end else begin
                        w_next_state   = S_TRACK;
                        w_next_elapsed = LAT_ONE;
                    end
                end
            end

            S_TRACK: begin
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else if (!dbus_ack) begin
                    w_next_elapsed = w_actual;
                end else if (w_actual < w_cur_tgt) begin
                    w_next_state  = S_FREEZE;
                    w_next_remain = w_cur_tgt - w_actual;
                end else begin
                    w_next_state = S_IDLE;
                end
            end

            S_FREEZE: begin
                // Bus activity is ignored here; a new start is only taken
                // from IDLE.
                if (!enable || (r_remain <= LAT_ONE)) begin
                    w_next_state  = S_IDLE;
                    w_next_remain = '0;
                end else begin
                    w_next_remain = r_remain - LAT_ONE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Statistics counters (clear beats any simultaneous increment)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            istall_cnt <= '0;
            dstall_cnt <= '0;
            freeze_cnt <= '0;
        end else begin
            rd_cnt     <= cnt_sat_inc(rd_cnt, w_start && dbus_read);
            wr_cnt     <= cnt_sat_inc(wr_cnt, w_start && !dbus_read);
            istall_cnt <= cnt_sat_inc(istall_cnt, ibus_stall);
            dstall_cnt <= cnt_sat_inc(dstall_cnt, dbus_stall);
            freeze_cnt <= cnt_sat_inc(freeze_cnt, r_freeze);
        end
    end

    assign freeze = r_freeze;
    assign busy   = (r_state != S_IDLE);

endmodule
